// File: rtl/cp0_timer_intc.sv
// cp0_timer_intc: shared prescaled count, N compare channels with sticky
// timer flags, software/external interrupt lines and a pending-interrupt
// latch that holds a request until the commit stage acknowledges it.
//
// Optional build macro: CP0_TIMER_IRQ_STATS_EN adds a saturating counter of
// accepted interrupt acknowledges, read at rsel=15 and cleared by wsel=15.
//
// Handshake: o_int_req is the valid; i_int_ack is the commit stage taking the
// interrupt in this cycle. An ack is accepted only when o_int_req is high.
// Once latched (PEND) the request stays up until acked, regardless of exl or
// the source dropping. o_int_line is stable for as long as PEND is held.
module cp0_timer_intc #(
  parameter int N_TIMERS = 2,
  parameter int DIV      = 2,
  parameter int N_SW     = 2,
  parameter int N_EXT    = 6,
  parameter int IRQ_W    = N_SW + N_EXT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_we,
  input  logic [3:0]          i_wsel,
  input  logic [31:0]         i_wd,
  input  logic [3:0]          i_rsel,
  output logic [31:0]         o_rd,
  input  logic                i_ie,
  input  logic                i_exl,
  input  logic [IRQ_W-1:0]    i_im,
  input  logic [N_EXT-1:0]    i_ext_int,
  output logic [N_TIMERS-1:0] o_ti,
  output logic [IRQ_W-1:0]    o_ip,
  output logic                o_int_req,
  output logic [3:0]          o_int_line,
  input  logic                i_int_ack,
  output logic                o_dbg_state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  logic [31:0]         r_count;
  logic [PW-1:0]       r_presc;
  logic [31:0]         r_compare [N_TIMERS];
  logic [N_TIMERS-1:0] r_ti;
  logic [N_SW-1:0]     r_sw_ip;
  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_line;

  logic                w_wr_count;
  logic                w_presc_wrap;
  logic [N_EXT-1:0]    w_ext_lines;
  logic [IRQ_W-1:0]    w_ip;
  logic [IRQ_W-1:0]    w_masked;
  logic [3:0]          w_line_comb;
  logic                w_raw_int;
  logic                w_pend;
  logic [31:0]         w_rd;

  assign w_wr_count   = i_we && (i_wsel == 4'd0);
  assign w_presc_wrap = (r_presc == PW'(DIV - 1));

  // Prescaler and shared count; a software count write wins over an increment.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_presc <= '0;
    end else if (w_wr_count) begin
      r_count <= i_wd;
      r_presc <= '0;
    end else if (w_presc_wrap) begin
      r_count <= r_count + 32'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Compare registers and sticky flags; a compare write clears its flag even on a hit.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_TIMERS; k++) begin
      if (i_reset) begin
        r_compare[k] <= 32'hFFFF_FFFF;
        r_ti[k]      <= 1'b0;
      end else if (i_we && (i_wsel == 4'(2 + k))) begin
        r_compare[k] <= i_wd;
        r_ti[k]      <= 1'b0;
      end else if (r_count == r_compare[k]) begin
        r_ti[k]      <= 1'b1;
      end
    end
  end

  // Software interrupt bits, written at their cause-register bit position.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sw_ip <= '0;
    end else if (i_we && (i_wsel == 4'd1)) begin
      r_sw_ip <= i_wd[N_SW+7:8];
    end
  end

  // External lines with the combined timer flag ORed into the top line.
  always_comb begin
    w_ext_lines          = i_ext_int;
    w_ext_lines[N_EXT-1] = i_ext_int[N_EXT-1] | (|r_ti);
  end

  assign w_ip      = {w_ext_lines, r_sw_ip};
  assign w_masked  = w_ip & i_im;
  assign w_raw_int = i_ie & ~i_exl & (|w_masked);

  // Highest set index of the masked lines; 0 when nothing is pending.
  always_comb begin
    w_line_comb = 4'd0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (w_masked[i]) begin
        w_line_comb = 4'(i);
      end
    end
  end

  // Next-state logic for the pending latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_raw_int && !i_int_ack) w_next_state = ST_PEND;
      ST_PEND: if (i_int_ack)               w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; the line number is frozen on entry to PEND.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_line  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && (w_next_state == ST_PEND)) begin
        r_line <= w_line_comb;
      end
    end
  end

  assign w_pend      = (r_state == ST_PEND);
  assign o_int_req   = w_raw_int | w_pend;
  assign o_int_line  = w_pend ? r_line : w_line_comb;
  assign o_ti        = r_ti;
  assign o_ip        = w_ip;
  assign o_dbg_state = r_state;

`ifdef CP0_TIMER_IRQ_STATS_EN
  logic [31:0] r_stats;

  // Saturating count of accepted acknowledges; a wsel=15 write clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stats <= '0;
    end else if (i_we && (i_wsel == 4'd15)) begin
      r_stats <= '0;
    end else if (i_int_ack && o_int_req && (r_stats != 32'hFFFF_FFFF)) begin
      r_stats <= r_stats + 32'd1;
    end
  end
`endif

  // Read mux over registered state.
  always_comb begin
    w_rd = 32'd0;
    if (i_rsel == 4'd0) begin
      w_rd = r_count;
    end else if (i_rsel == 4'd1) begin
      w_rd = 32'(w_ip) << 8;
    end
    for (int k = 0; k < N_TIMERS; k++) begin
      if (i_rsel == 4'(2 + k)) begin
        w_rd = r_compare[k];
      end
    end
`ifdef CP0_TIMER_IRQ_STATS_EN
    if (i_rsel == 4'd15) begin
      w_rd = r_stats;
    end
`endif
  end

  assign o_rd = w_rd;

endmodule

// File: doc/cp0_timer_intc.md
Name: cp0_timer_intc

Overview:
- Parametrised successor to the CP0 count/compare and interrupt-detect logic.
- Provides one shared free-running count with a programmable prescaler, N independent compare channels with sticky timer-interrupt flags, software and external interrupt lines, and a pending-interrupt latch with a delivery handshake to the commit stage.
- Sits beside the CP0 register file. CP0 supplies status.ie/exl/im and drives reads and writes through the select port.

Parameters:
N_TIMERS, 2, number of compare channels (1..12)
DIV, 2, count increments once every DIV cycles (1..16)
N_SW, 2, software interrupt lines (ip[N_SW-1:0])
N_EXT, 6, external interrupt lines (ip[IRQ_W-1:N_SW])
IRQ_W, N_SW+N_EXT, total interrupt lines; the timer ORs into line IRQ_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we  in  1  register write strobe
wsel  in  4  write select: 0 count, 1 sw ip, 2+k compare k
wd  in  32  write data
rsel  in  4  read select (same map; 15 = stats when the optional feature is compiled in)
rd  out  32  combinational read data
ie  in  1  status.ie
exl  in  1  status.exl
im  in  IRQ_W  status.im
ext_int  in  N_EXT  external interrupt inputs (level)
ti  out  N_TIMERS  sticky timer flags
ip  out  IRQ_W  cause.ip view
int_req  out  1  interrupt requested (raw or latched)
int_line  out  4  index of the highest set line of (ip & im)
int_ack  in  1  commit stage took the interrupt this cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - count=0, prescaler=0, compare[k]=32'hFFFF_FFFF, ti=0, sw ip=0.
  - FSM=IDLE; int_req=0; int_line=0.
- Prescaler:
  - Increments each cycle and wraps at DIV-1.
  - On the wrap cycle count <= count+1, modulo 2^32 (32'hFFFF_FFFF -> 0).
  - DIV=1: count increments every cycle.
- Count write (we & wsel==0):
  - count <= wd and prescaler <= 0.
  - The write wins over a same-cycle increment.
- Compare hit:
  - Each cycle, if count_q == compare_q[k], ti[k] <= 1. The flag is sticky.
  - Writing compare k (we & wsel==2+k) sets compare[k] <= wd and clears ti[k]. The clear wins over a same-cycle hit.
  - Writes to wsel >= 2+N_TIMERS are ignored.
- Software ip write (we & wsel==1): sw ip <= wd[N_SW+7:8], matching the cause bit position. Other bits are ignored.
- Line view:
  - ip = {ext_int | ({N_EXT{1'b0}} with bit N_EXT-1 = |ti), sw ip}.
  - The timer ORs into the top line.
- raw_int = ie & ~exl & |(ip & im), combinational from registered state.
- FSM, two states:
  - IDLE -> PEND when raw_int & ~int_ack.
  - PEND -> IDLE on int_ack.
  - PEND holds through exl=1 and deassertion of the source; the latch is not re-qualified.
  - int_req = raw_int | (state==PEND).
  - int_ack with int_req=0 is ignored.
- int_line:
  - The highest set index of ip & im.
  - Registered into PEND on IDLE->PEND and held while in PEND.
  - In IDLE it tracks combinationally; 0 if nothing is set.
- Reads:
  - rsel 0 count, 1 {ip in [N_SW+N_EXT+7:8]}, 2+k compare[k]; others 0.
  - Reads return pre-write (registered) values.
- Reset mid-operation clears PEND and all flags in the same edge. No int_req follows reset.

Optional Feature:
- CP0_TIMER_IRQ_STATS_EN defined:
  - Adds a 32-bit counter incremented on every accepted int_ack (int_ack & int_req); it saturates at 32'hFFFF_FFFF.
  - The counter is readable at rsel=15 and cleared by reset or by a write with wsel=15.
- Undefined:
  - No counter.
  - rsel=15 reads 0; wsel=15 is ignored.

Test Plan:
- DIV=2, count written to 32'hFFFF_FFFE: count reads FFFF_FFFF after 2 cycles, then 0 after 2 more. Wrap check.
- compare[1]=5, ie=1, exl=0, im[7]=1, count from 0, DIV=1: ti[1] rises at cycle 6, then int_req=1 and int_line=7. Write compare[1] -> ti[1]=0 the next cycle.
- Count reaches compare[0] in the same cycle compare[0] is written: ti[0] stays 0 and compare holds the new value.
- ext_int[2] pulses 1 cycle with im[4]=1 and no ack: PEND holds, int_req=1 and int_line=4 persist after the pulse ends. int_ack -> int_req=0 the next cycle.
- Software write wd=32'h100, im[0]=1, exl=1: no int_req. exl->0: int_req=1, int_line=0.
- With CP0_TIMER_IRQ_STATS_EN: 3 acked interrupts -> rsel=15 reads 3; reset asserted while PEND -> int_req=0 and stats=0.
